// File: rtl/alu_out_stage_if.sv
// Handshake/bus bundle between the ALU, the output stage and the write-back consumer.
interface alu_out_stage_if #(parameter int WIDTH = 32);
  // upstream (ALU) side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             branch_taken;
  logic             carry;
  logic             borrow;
  logic             hilo_wr;
  logic [1:0]       out_sel;
  logic             flush;
  // downstream (write-back/branch) side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_branch_taken;
  logic             out_carry;
  logic             out_borrow;
  // architectural HI/LO
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // driver of the stage's inputs (ALU + consumer)
  modport master (
    output in_valid, result, result_hi, branch_taken, carry, borrow, hilo_wr, out_sel, flush,
    output out_ready,
    input  in_ready, out_valid, out_data, out_branch_taken, out_carry, out_borrow, hi, lo
  );

  // the stage itself
  modport slave (
    input  in_valid, result, result_hi, branch_taken, carry, borrow, hilo_wr, out_sel, flush,
    input  out_ready,
    output in_ready, out_valid, out_data, out_branch_taken, out_carry, out_borrow, hi, lo
  );
endinterface

// File: rtl/alu_out_stage.sv
// ALU output stage: HI/LO registers, write-back word select, 2-entry skid buffer.
module alu_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_out_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             branch_taken;
    logic             carry;
    logic             borrow;
  } beat_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state;
  beat_t            main_q, skid_q, beat_in;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             acc, pop;

  // in_ready/out_valid come straight off the state register; no path from out_ready
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);

  // flush kills the incoming beat, including its HI/LO write
  assign acc = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop = bus.out_valid & bus.out_ready;

  // write-back word select; a same-beat HI/LO write forwards around the registers
  always_comb begin
    beat_in              = '0;
    beat_in.branch_taken = bus.branch_taken;
    beat_in.carry        = bus.carry;
    beat_in.borrow       = bus.borrow;
    case (bus.out_sel)
      2'b00:   beat_in.data = bus.result;
      2'b01:   beat_in.data = bus.hilo_wr ? bus.result    : lo_q;
      2'b10:   beat_in.data = bus.hilo_wr ? bus.result_hi : hi_q;
      default: beat_in.data = '0;
    endcase
  end

  // HI/LO architectural registers; untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (acc && bus.hilo_wr) begin
      hi_q <= bus.result_hi;
      lo_q <= bus.result;
    end
  end

  // skid buffer FSM: main is the presented entry, skid catches the beat accepted under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          main_q <= beat_in;
          state  <= ONE;
        end
        ONE: begin
          if (acc && pop) begin
            main_q <= beat_in;
          end else if (acc) begin
            skid_q <= beat_in;
            state  <= FULL;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        FULL: if (pop) begin
          main_q <= skid_q;
          state  <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.out_data         = main_q.data;
  assign bus.out_branch_taken = main_q.branch_taken;
  assign bus.out_carry        = main_q.carry;
  assign bus.out_borrow       = main_q.borrow;
  assign bus.hi               = hi_q;
  assign bus.lo               = lo_q;

endmodule

// File: tb/tb_alu_out_stage.sv
// Directed bench for alu_out_stage: reset, select/forwarding, backpressure, flush.
module tb_alu_out_stage;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_out_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_out_stage #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.result = '0; bus.result_hi = '0; bus.branch_taken = 0;
    bus.carry = 0; bus.borrow = 0; bus.hilo_wr = 0; bus.out_sel = 2'b00; bus.flush = 0;
  endtask

  task automatic push(input logic [31:0] r, input logic [31:0] rh, input logic hw,
                      input logic [1:0] sel, input logic bt, input logic cy, input logic bw);
    bus.in_valid = 1; bus.result = r; bus.result_hi = rh; bus.hilo_wr = hw;
    bus.out_sel = sel; bus.branch_taken = bt; bus.carry = cy; bus.borrow = bw;
  endtask

  task automatic test_reset();
    rst = 1; idle(); bus.out_ready = 0;
    #12;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("FAIL rst_hilo got %h/%h exp 0/0", bus.hi, bus.lo); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
    #3 rst = 0;
    step();
  endtask

  task automatic test_single();
    bus.out_ready = 1;
    push(32'h5, 32'h0, 0, 2'b00, 0, 0, 0);
    step(); idle();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5) begin bad++; $display("FAIL single_data got v=%b %h exp v=1 00000005", bus.out_valid, bus.out_data); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_mult_mfhi();
    bus.out_ready = 1;
    push(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 2'b00, 1, 1, 0);
    step();
    total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_hilo got %h/%h exp ffffffff/fffffffe", bus.hi, bus.lo); end
    total++; if (bus.out_data !== 32'hFFFF_FFFE || bus.out_branch_taken !== 1'b1 || bus.out_carry !== 1'b1)
      begin bad++; $display("FAIL mult_beat got %h bt=%b c=%b exp fffffffe bt=1 c=1", bus.out_data, bus.out_branch_taken, bus.out_carry); end
    push(32'h0, 32'h0, 0, 2'b10, 0, 0, 0);
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mfhi got %h exp ffffffff", bus.out_data); end
    push(32'h0, 32'h0, 0, 2'b01, 0, 0, 0);
    step();
    total++; if (bus.out_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mflo got %h exp fffffffe", bus.out_data); end
    push(32'hAAAA_AAAA, 32'h0, 0, 2'b11, 0, 0, 0);
    step();
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL sel_reserved got %h exp 0", bus.out_data); end
    idle(); step();
  endtask

  task automatic test_forward();
    bus.out_ready = 1;
    push(32'h1234, 32'h5678, 1, 2'b01, 0, 0, 0);
    step();
    total++; if (bus.out_data !== 32'h1234) begin bad++; $display("FAIL fwd_lo got %h exp 00001234", bus.out_data); end
    total++; if (bus.hi !== 32'h5678 || bus.lo !== 32'h1234) begin bad++; $display("FAIL fwd_hilo got %h/%h exp 00005678/00001234", bus.hi, bus.lo); end
    push(32'h1, 32'h9ABC, 1, 2'b10, 0, 0, 0);
    step();
    total++; if (bus.out_data !== 32'h9ABC) begin bad++; $display("FAIL fwd_hi got %h exp 00009abc", bus.out_data); end
    idle(); step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 0;
    push(32'hA, 32'h0, 0, 2'b00, 0, 0, 1);
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_data !== 32'hA)
      begin bad++; $display("FAIL bp_a got v=%b r=%b %h exp v=1 r=1 0000000a", bus.out_valid, bus.in_ready, bus.out_data); end
    push(32'hB, 32'h0, 0, 2'b00, 0, 0, 0);
    step();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got in_ready=%b exp 0", bus.in_ready); end
    // not accepted while full: its hilo_wr must be ignored
    push(32'h111, 32'h777, 1, 2'b00, 0, 0, 0);
    step(); idle();
    total++; if (bus.hi !== 32'h9ABC || bus.lo !== 32'h1) begin bad++; $display("FAIL bp_hilo_ignored got %h/%h exp 00009abc/00000001", bus.hi, bus.lo); end
    total++; if (bus.out_data !== 32'hA || bus.out_borrow !== 1'b1) begin bad++; $display("FAIL bp_stable got %h b=%b exp 0000000a b=1", bus.out_data, bus.out_borrow); end
    bus.out_ready = 1;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB || bus.out_borrow !== 1'b0 || bus.in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_b got v=%b %h b=%b r=%b exp v=1 0000000b b=0 r=1", bus.out_valid, bus.out_data, bus.out_borrow, bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 0;
    push(32'hC, 32'h0, 0, 2'b00, 0, 0, 0); step();
    push(32'hD, 32'h0, 0, 2'b00, 0, 0, 0); step();
    push(32'hDEAD, 32'hBEEF, 1, 2'b00, 0, 0, 0); bus.flush = 1;
    step(); idle();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_full got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready); end
    total++; if (bus.hi !== 32'h9ABC || bus.lo !== 32'h1) begin bad++; $display("FAIL flush_full_hilo got %h/%h exp 00009abc/00000001", bus.hi, bus.lo); end
    // flush from ONE, where the beat would otherwise have been accepted
    push(32'hE, 32'h0, 0, 2'b00, 0, 0, 0); step();
    push(32'h4321, 32'h8765, 1, 2'b00, 0, 0, 0); bus.flush = 1;
    step(); idle();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_one got v=%b exp 0", bus.out_valid); end
    total++; if (bus.hi !== 32'h9ABC || bus.lo !== 32'h1) begin bad++; $display("FAIL flush_one_hilo got %h/%h exp 00009abc/00000001", bus.hi, bus.lo); end
    bus.out_ready = 1;
    step(); step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got v=%b %h exp v=0", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 0;
    push(32'h55, 32'h66, 1, 2'b00, 0, 0, 0); step(); idle();
    total++; if (bus.out_valid !== 1'b1 || bus.hi !== 32'h66) begin bad++; $display("FAIL pre_rst got v=%b hi=%h exp v=1 hi=00000066", bus.out_valid, bus.hi); end
    #2 rst = 1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_hs got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready); end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("FAIL mid_rst_hilo got %h/%h exp 0/0", bus.hi, bus.lo); end
    #2 rst = 0;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL post_rst got v=%b exp 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mult_mfhi();
    test_forward();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time bound so the run always ends
  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
